// File: rtl/cntr_share_arb_if.sv
// Handshake bundle between the control FSMs (master) and the shared interval counter arbiter (slave).
interface cntr_share_arb_if #(parameter int WIDTH = 8);
  logic [1:0]       req;
  logic [WIDTH-1:0] dur0;
  logic [WIDTH-1:0] dur1;
  logic             hold;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] count;
  logic [1:0]       done;
  logic             busy;

  modport master (output req, dur0, dur1, hold, input gnt, count, done, busy);
  modport slave  (input req, dur0, dur1, hold, output gnt, count, done, busy);
endinterface

// File: rtl/cntr_share_arb.sv
// Round-robin owner of a single interval counter shared by two requesters.
// Every output is a register or decoded from the registered state.
module cntr_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  cntr_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, REL} state_t;

  state_t           state, state_n;
  logic [1:0]       gnt, gnt_n;
  logic [1:0]       done, done_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] dur_q, dur_n;
  logic             last, last_n;
  logic             winner;
  logic             owner;

  // State register; last-served starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      gnt   <= 2'b00;
      done  <= 2'b00;
      count <= '0;
      dur_q <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      count <= count_n;
      dur_q <= dur_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = 2'b00;
    count_n = count;
    dur_n   = dur_q;
    last_n  = last;
    winner  = 1'b0;
    owner   = gnt[1];

    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          winner  = (bus.req == 2'b11) ? ~last : bus.req[1];
          state_n = RUN;
          gnt_n   = winner ? 2'b10 : 2'b01;
          count_n = '0;
          dur_n   = winner ? bus.dur1 : bus.dur0;
          last_n  = winner;
        end
      end
      // Abort beats hold, hold beats completion.
      RUN: begin
        if (!bus.req[owner]) begin
          state_n = IDLE;
          gnt_n   = 2'b00;
          count_n = '0;
        end else if (bus.hold) begin
          state_n = RUN;
        end else if (count == dur_q) begin
          state_n = REL;
          gnt_n   = 2'b00;
          done_n  = gnt;
        end else begin
          count_n = count + WIDTH'(1);
        end
      end
      REL: begin
        state_n = IDLE;
        count_n = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
        count_n = '0;
      end
    endcase
  end

  assign bus.gnt   = gnt;
  assign bus.done  = done;
  assign bus.count = count;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_cntr_share_arb.sv
// Self-checking bench for cntr_share_arb: per-feature tasks plus a done-pulse scoreboard.
module tb_cntr_share_arb;

  typedef struct {
    logic [1:0] who;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rstb;
  int   checks;
  int   fails;
  bit   mon_en;
  exp_t sbq[$];

  cntr_share_arb_if #(.WIDTH(8)) bus ();

  cntr_share_arb #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every done pulse must match the oldest expected completion, owner and final count.
  always @(negedge clk) begin
    if (mon_en && bus.done !== 2'b00) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected_done: done=%b count=%0d, required no pulse", bus.done, bus.count);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.done !== e.who || bus.count !== e.d) begin
          fails++;
          $display("[TB] FAIL sb_done: done=%b count=%0d, required done=%b count=%0d",
                   bus.done, bus.count, e.who, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 2'b00; bus.hold = 1'b0; bus.dur0 = 8'd0; bus.dur1 = 8'd0;
    do_reset();
    checks++; if (bus.gnt !== 2'b00) begin fails++; $display("[TB] FAIL por_gnt: got %b, required 00", bus.gnt); end
    checks++; if (bus.count !== 8'd0) begin fails++; $display("[TB] FAIL por_count: got %0d, required 0", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL por_busy: got %b, required 0", bus.busy); end
    mon_en = 1'b1;
    bus.req = 2'b01; bus.dur0 = 8'd20;
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.count !== 8'd5) begin fails++; $display("[TB] FAIL rst_pre_count: got %0d, required 5", bus.count); end
    rstb = 1'b0;
    tick();
    checks++; if (bus.gnt !== 2'b00) begin fails++; $display("[TB] FAIL rst_gnt: got %b, required 00", bus.gnt); end
    checks++; if (bus.count !== 8'd0) begin fails++; $display("[TB] FAIL rst_count: got %0d, required 0", bus.count); end
    checks++; if (bus.done !== 2'b00) begin fails++; $display("[TB] FAIL rst_done: got %b, required 00", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b, required 0", bus.busy); end
    tick();
    bus.req = 2'b00;
    rstb = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_after_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_single();
    bus.req = 2'b01; bus.dur0 = 8'd3;
    sbq.push_back('{2'b01, 8'd3});
    tick();
    checks++; if (bus.gnt !== 2'b01) begin fails++; $display("[TB] FAIL single_gnt: got %b, required 01", bus.gnt); end
    checks++; if (bus.count !== 8'd0) begin fails++; $display("[TB] FAIL single_count0: got %0d, required 0", bus.count); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.count !== 8'(i)) begin fails++; $display("[TB] FAIL single_count: got %0d, required %0d", bus.count, i); end
    end
    tick();
    checks++; if (bus.done !== 2'b01 || bus.gnt !== 2'b00) begin fails++; $display("[TB] FAIL single_rel: done=%b gnt=%b, required 01 00", bus.done, bus.gnt); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 2'b00) begin fails++; $display("[TB] FAIL single_idle: busy=%b done=%b, required 0 00", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] who;
    logic [7:0] d;
    do_reset();
    bus.dur0 = 8'd2; bus.dur1 = 8'd1; bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      who = (k % 2 == 0) ? 2'b01 : 2'b10;
      d   = (k % 2 == 0) ? 8'd2 : 8'd1;
      sbq.push_back('{who, d});
      tick();
      checks++; if (bus.gnt !== who) begin fails++; $display("[TB] FAIL tie_gnt%0d: got %b, required %b", k, bus.gnt, who); end
      for (int i = 0; i < int'(d); i++) tick();
      checks++; if (bus.count !== d) begin fails++; $display("[TB] FAIL tie_count%0d: got %0d, required %0d", k, bus.count, d); end
      tick();
      checks++; if (bus.done !== who) begin fails++; $display("[TB] FAIL tie_done%0d: got %b, required %b", k, bus.done, who); end
      if (k == 3) bus.req = 2'b00;
      tick();
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL tie_idle%0d: got %b, required 0", k, bus.busy); end
    end
  endtask

  task automatic test_hold();
    bus.req = 2'b10; bus.dur1 = 8'd4;
    sbq.push_back('{2'b10, 8'd4});
    tick();
    tick();
    tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.count !== 8'd2 || bus.gnt !== 2'b10) begin fails++; $display("[TB] FAIL hold_mid%0d: count=%0d gnt=%b, required 2 10", i, bus.count, bus.gnt); end
    end
    bus.hold = 1'b0;
    tick();
    tick();
    checks++; if (bus.count !== 8'd4) begin fails++; $display("[TB] FAIL hold_reach: got %0d, required 4", bus.count); end
    bus.hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.done !== 2'b00 || bus.count !== 8'd4) begin fails++; $display("[TB] FAIL hold_end%0d: done=%b count=%0d, required 00 4", i, bus.done, bus.count); end
    end
    bus.hold = 1'b0;
    tick();
    checks++; if (bus.done !== 2'b10) begin fails++; $display("[TB] FAIL hold_done: got %b, required 10", bus.done); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_abort();
    bus.req = 2'b01; bus.dur0 = 8'd10; bus.dur1 = 8'd3;
    tick();
    bus.req = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.count !== 8'd6 || bus.gnt !== 2'b01) begin fails++; $display("[TB] FAIL abort_pre: count=%0d gnt=%b, required 6 01", bus.count, bus.gnt); end
    bus.req = 2'b10;
    tick();
    checks++; if (bus.gnt !== 2'b00 || bus.count !== 8'd0 || bus.done !== 2'b00) begin fails++; $display("[TB] FAIL abort_drop: gnt=%b count=%0d done=%b, required 00 0 00", bus.gnt, bus.count, bus.done); end
    sbq.push_back('{2'b10, 8'd3});
    tick();
    checks++; if (bus.gnt !== 2'b10 || bus.count !== 8'd0) begin fails++; $display("[TB] FAIL abort_next: gnt=%b count=%0d, required 10 0", bus.gnt, bus.count); end
    bus.dur1 = 8'd200;
    for (int i = 0; i < 3; i++) tick();
    tick();
    checks++; if (bus.done !== 2'b10) begin fails++; $display("[TB] FAIL abort_dur_q: done=%b, required 10", bus.done); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_boundary();
    bus.req = 2'b01; bus.dur0 = 8'd0;
    sbq.push_back('{2'b01, 8'd0});
    tick();
    checks++; if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL d0_gnt: gnt=%b busy=%b, required 01 1", bus.gnt, bus.busy); end
    tick();
    checks++; if (bus.done !== 2'b01 || bus.gnt !== 2'b00) begin fails++; $display("[TB] FAIL d0_done: done=%b gnt=%b, required 01 00", bus.done, bus.gnt); end
    bus.req = 2'b00;
    tick();
    bus.req = 2'b01; bus.dur0 = 8'd255;
    sbq.push_back('{2'b01, 8'd255});
    tick();
    for (int i = 1; i <= 255; i++) begin
      tick();
      checks++; if (bus.count !== 8'(i) || bus.done !== 2'b00) begin fails++; $display("[TB] FAIL dmax_count: count=%0d done=%b, required %0d 00", bus.count, bus.done, i); end
    end
    tick();
    checks++; if (bus.done !== 2'b01 || bus.count !== 8'd255) begin fails++; $display("[TB] FAIL dmax_done: done=%b count=%0d, required 01 255", bus.done, bus.count); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.count !== 8'd0 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL dmax_idle: count=%0d busy=%b, required 0 0", bus.count, bus.busy); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    mon_en = 1'b0;
    rstb   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_abort();
    test_boundary();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("[TB] FAIL sb_leftover: %0d completions outstanding, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
